// File: rtl/vharray_ctrl.sv
// vharray_ctrl: issues raster-ordered windows to a PE array and numbers its results.
// Ports: clk/rst_n, start+out_h/out_w job launch, hold stall, arr_in_valid+win_row/win_col
// issue, arr_out_valid -> res_we/res_addr writes, busy/done status; wd_err with VHCTRL_WATCHDOG_EN.
module vharray_ctrl #(
  parameter int ARRAYLEN  = 25,
  parameter int DIMWIDTH  = 8,
  parameter int ADDRWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIMWIDTH-1:0]  out_h,
  input  logic [DIMWIDTH-1:0]  out_w,
  input  logic                 hold,
  output logic                 arr_in_valid,
  output logic [DIMWIDTH-1:0]  win_row,
  output logic [DIMWIDTH-1:0]  win_col,
  input  logic                 arr_out_valid,
  output logic                 res_we,
  output logic [ADDRWIDTH-1:0] res_addr,
  output logic                 busy,
  output logic                 done
`ifdef VHCTRL_WATCHDOG_EN
  ,
  output logic                 wd_err
`endif
);

  localparam int PW = 2 * DIMWIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state;
  logic [DIMWIDTH-1:0]  h_q;
  logic [DIMWIDTH-1:0]  w_q;
  logic [PW-1:0]        total;
  logic [ADDRWIDTH-1:0] last_addr;
  logic                 zero_dim;
  logic                 last_win;
  logic                 last_col;
  logic                 collect;
  logic                 last_wr;

  // Full-width product; only its low ADDRWIDTH bits address results.
  assign total     = PW'(h_q) * PW'(w_q);
  assign last_addr = ADDRWIDTH'(total - PW'(1));
  assign zero_dim  = (out_h == '0) || (out_w == '0);
  assign last_col  = (win_col == w_q - DIMWIDTH'(1));
  assign last_win  = last_col && (win_row == h_q - DIMWIDTH'(1));

  // Stall and result strobes must act in the same cycle.
  assign arr_in_valid = (state == S_ISSUE) && !hold;
  assign collect      = (state == S_ISSUE) || (state == S_DRAIN);
  assign res_we       = collect && arr_out_valid;
  assign last_wr      = res_we && (res_addr == last_addr);

`ifdef VHCTRL_WATCHDOG_EN
  localparam int WDW = $clog2(ARRAYLEN + 3);
  logic [WDW-1:0] wd_cnt;
  logic           wd_idle;
  logic           wd_fire;

  assign wd_idle = (state == S_DRAIN) && !arr_out_valid;
  assign wd_fire = wd_idle && (wd_cnt == WDW'(ARRAYLEN + 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      h_q      <= '0;
      w_q      <= '0;
      win_row  <= '0;
      win_col  <= '0;
      res_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef VHCTRL_WATCHDOG_EN
      wd_cnt   <= '0;
      wd_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            win_row  <= '0;
            win_col  <= '0;
            res_addr <= '0;
`ifdef VHCTRL_WATCHDOG_EN
            wd_err   <= 1'b0;
`endif
            if (zero_dim) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ISSUE;
              busy  <= 1'b1;
              h_q   <= out_h;
              w_q   <= out_w;
            end
          end
        end
        S_ISSUE: begin
          if (res_we) res_addr <= res_addr + ADDRWIDTH'(1);
          if (arr_in_valid) begin
            if (last_win) begin
              state <= S_DRAIN;
            end else if (last_col) begin
              win_col <= '0;
              win_row <= win_row + DIMWIDTH'(1);
            end else begin
              win_col <= win_col + DIMWIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if (res_we) res_addr <= res_addr + ADDRWIDTH'(1);
          if (last_wr) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`ifdef VHCTRL_WATCHDOG_EN
          else if (wd_fire) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            wd_err <= 1'b1;
          end
`endif
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
`ifdef VHCTRL_WATCHDOG_EN
      // Counts back-to-back silent drain cycles only.
      wd_cnt <= wd_idle ? wd_cnt + WDW'(1) : '0;
`endif
    end
  end

endmodule

// File: tb/tb_vharray_ctrl.sv
// tb_vharray_ctrl: random and directed jobs with a delay-line array model;
// a scoreboard monitor checks issues, writes and done timing.
module tb_vharray_ctrl;

  localparam int AL  = 25;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int LAT = AL + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          stray = 1'b0;
  logic [DW-1:0] out_h = '0;
  logic [DW-1:0] out_w = '0;
  logic          arr_in_valid;
  logic [DW-1:0] win_row;
  logic [DW-1:0] win_col;
  logic          arr_out_valid;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic          busy;
  logic          done;
`ifdef VHCTRL_WATCHDOG_EN
  logic          wd_err;
`endif

  vharray_ctrl #(
    .ARRAYLEN (AL),
    .DIMWIDTH (DW),
    .ADDRWIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .out_h        (out_h),
    .out_w        (out_w),
    .hold         (hold),
    .arr_in_valid (arr_in_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .arr_out_valid(arr_out_valid),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .busy         (busy),
    .done         (done)
`ifdef VHCTRL_WATCHDOG_EN
    ,
    .wd_err       (wd_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int row; int col; int cyc;} win_t;
  typedef struct {int addr; int cyc;} wr_t;

  win_t exp_win[$];
  wr_t  exp_wr[$];
  int   exp_done[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  int drop_r = -1;
  int drop_c = -1;
  bit mon_en = 1'b1;

  logic           in_cap = 1'b0;
  logic [LAT-1:0] pipe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: fixed latency LAT, optionally losing one window's result.
  always @(negedge clk)
    in_cap <= arr_in_valid &&
              !(int'(win_row) == drop_r && int'(win_col) == drop_c);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= '0;
    else pipe <= {pipe[LAT-2:0], in_cap};

  assign arr_out_valid = pipe[LAT-1] | stray;

  always @(negedge clk)
    if (rst_n && done) done_seen <= done_seen + 1;

  always @(negedge clk) begin : mon
    win_t e;
    wr_t  f;
    int   d;
    if (rst_n && mon_en) begin
      if (arr_in_valid) begin
        if (exp_win.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          e = exp_win.pop_front();
          chk("win_row", win_row, e.row);
          chk("win_col", win_col, e.col);
          chk("issue_cyc", cyc, e.cyc);
        end
      end
      if (res_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          f = exp_wr.pop_front();
          chk("res_addr", res_addr, f.addr);
          chk("write_cyc", cyc, f.cyc);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("done_cyc", cyc, d);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  // Reference: walk the hold pattern cycle by cycle, one window per free cycle.
  task automatic run_job(input int h, input int w, input logic [127:0] hm,
                         input int spam_rel, input bit drop);
    int c0, rel, idx, lastc, lw, n, done_abs;
    @(posedge clk);
    #1;
    c0 = cyc;
    n = h * w;
    drop_r = drop ? h - 1 : -1;
    drop_c = drop ? w - 1 : -1;
    idx = 0;
    rel = 1;
    lastc = 0;
    lw = -1;
    while (idx < n) begin
      if (!(rel < 128 && hm[rel])) begin
        exp_win.push_back('{idx / w, idx % w, c0 + rel});
        if (!(drop && idx == n - 1)) begin
          exp_wr.push_back('{idx, c0 + rel + LAT});
          lw = c0 + rel + LAT;
        end
        lastc = rel;
        idx++;
      end
      rel++;
    end
    if (n == 0) done_abs = c0 + 1;
    else if (drop) done_abs = lw + AL + 3;
    else done_abs = c0 + lastc + LAT + 1;
    exp_done.push_back(done_abs);
    start = 1'b1;
    out_h = DW'(h);
    out_w = DW'(w);
    hold = 1'b0;
    rel = 0;
    while (exp_done.size() != 0 && rel < 600) begin
      @(posedge clk);
      #1;
      rel++;
      start = (rel == spam_rel);
      if (start) begin
        out_h = DW'($urandom_range(1, 9));
        out_w = DW'($urandom_range(1, 9));
      end
      hold = (rel < 128) ? hm[rel] : 1'b0;
      if (c0 + rel < done_abs) chk("busy", busy, (n > 0));
    end
    start = 1'b0;
    hold = 1'b0;
    if (exp_done.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_done.delete();
    end
    chk("leftover_issue", exp_win.size(), 0);
    chk("leftover_write", exp_wr.size(), 0);
    exp_win.delete();
    exp_wr.delete();
    drop_r = -1;
    drop_c = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] hm;
    int d0;
    #12;
    chk("rst_in_valid", arr_in_valid, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_res_addr", res_addr, 0);
`ifdef VHCTRL_WATCHDOG_EN
    chk("rst_wd_err", wd_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    hm = '0;
    run_job(2, 3, hm, 0, 1'b0);
    hm[3] = 1'b1;
    hm[4] = 1'b1;
    run_job(2, 3, hm, 0, 1'b0);
    hm = '0;
    run_job(3, 0, hm, 0, 1'b0);
    run_job(0, 4, hm, 0, 1'b0);
    run_job(3, 3, hm, 2, 1'b0);
`ifdef VHCTRL_WATCHDOG_EN
    chk("wd_err_clean", wd_err, 0);
`endif

    // Array output while idle must not produce a write.
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(negedge clk);
    chk("idle_stray_we", res_we, 0);
    @(posedge clk);
    #1;
    stray = 1'b0;

    // Reset in the middle of a 4x4 job.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    out_h = 8'd4;
    out_w = 8'd4;
    repeat (10) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk("prerst_issue", arr_in_valid, 1);
    chk("prerst_row", win_row, 2);
    chk("prerst_col", win_col, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_valid", arr_in_valid, 0);
    chk("midrst_res_we", res_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_win_row", win_row, 0);
    chk("midrst_win_col", win_col, 0);
    chk("midrst_res_addr", res_addr, 0);
    d0 = done_seen;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("no_done_after_rst", done_seen, d0);
    chk("idle_after_rst", busy, 0);

    for (int j = 0; j < 12; j++) begin
      int h, w, sp;
      h = (j % 5 == 4) ? 0 : $urandom_range(1, 6);
      w = $urandom_range(1, 6);
      hm = {$urandom, $urandom, $urandom, $urandom} &
           {$urandom, $urandom, $urandom, $urandom};
      sp = ($urandom_range(0, 1) == 1) ? 1 : 0;
      run_job(h, w, hm, sp, 1'b0);
    end

`ifdef VHCTRL_WATCHDOG_EN
    hm = '0;
    run_job(2, 3, hm, 0, 1'b1);
    chk("wd_err_set", wd_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("wd_err_sticky", wd_err, 1);
    run_job(1, 2, hm, 0, 1'b0);
    chk("wd_err_cleared", wd_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
